// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_pkg                                                      |
// | Description : Shared widths, sample types and round/saturate helper for    |
// |               the 8-point FFT twiddle multiplier.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int DW   = 10;
    localparam int TW   = 10;
    localparam int FRAC = 8;
    localparam int N_PT = 8;

    localparam int C_AW = $clog2(N_PT);
    localparam int C_PW = DW + TW;
    localparam int C_SW = DW + TW + 1;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW-1:0] re;
        logic signed [TW-1:0] im;
    } tw_t;

    // Round half up, drop FRAC bits, clip to the signed DW range.
    function automatic logic signed [DW-1:0] sat_round(input logic signed [C_SW-1:0] v);
        logic signed [C_SW-1:0] r;
        r = v + C_SW'(1 << (FRAC - 1));
        r = r >>> FRAC;
        if (r[C_SW-1:DW-1] == {(C_SW-DW+1){r[C_SW-1]}}) begin
            return r[DW-1:0];
        end
        return r[C_SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmul_pipe                                                    |
// | Description : Two-stage complex multiply (products, then sum/round/sat)    |
// |               with a shared advance enable.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cmul_pipe
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  in_valid,
    input  logic  in_last,
    input  cplx_t x,
    input  tw_t   w,
    output logic  out_valid,
    output logic  out_last,
    output cplx_t y
);

    logic signed [C_PW-1:0] ar_d, bi_d, ai_d, br_d;
    logic signed [C_PW-1:0] ar_q, bi_q, ai_q, br_q;
    logic                   v2_d, v2_q, l2_d, l2_q;
    logic signed [C_SW-1:0] w_pr, w_pi;
    cplx_t                  y_d, y_q;
    logic                   vo_d, vo_q, lo_d, lo_q;

    always_comb begin
        ar_d = ar_q;
        bi_d = bi_q;
        ai_d = ai_q;
        br_d = br_q;
        v2_d = v2_q;
        l2_d = l2_q;
        y_d  = y_q;
        vo_d = vo_q;
        lo_d = lo_q;
        w_pr = C_SW'(ar_q) - C_SW'(bi_q);
        w_pi = C_SW'(ai_q) + C_SW'(br_q);
        if (en) begin
            ar_d = C_PW'($signed(x.re)) * C_PW'($signed(w.re));
            bi_d = C_PW'($signed(x.im)) * C_PW'($signed(w.im));
            ai_d = C_PW'($signed(x.re)) * C_PW'($signed(w.im));
            br_d = C_PW'($signed(x.im)) * C_PW'($signed(w.re));
            v2_d = in_valid;
            l2_d = in_last;
            y_d.re = sat_round(w_pr);
            y_d.im = sat_round(w_pi);
            vo_d = v2_q;
            lo_d = l2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q <= '0;
            bi_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            v2_q <= 1'b0;
            l2_q <= 1'b0;
            y_q  <= '0;
            vo_q <= 1'b0;
            lo_q <= 1'b0;
        end else begin
            ar_q <= ar_d;
            bi_q <= bi_d;
            ai_q <= ai_d;
            br_q <= br_d;
            v2_q <= v2_d;
            l2_q <= l2_d;
            y_q  <= y_d;
            vo_q <= vo_d;
            lo_q <= lo_d;
        end
    end

    assign out_valid = vo_q;
    assign out_last  = lo_q;
    assign y         = y_q;

endmodule
`default_nettype wire

// File: rtl/fft_tw_mul8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_tw_mul8                                                  |
// | Description : Streaming twiddle multiplier for an 8-point FFT stage; owns  |
// |               the block index counter, ROM address and handshakes.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_tw_mul8
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic [2:0]           tw_addr,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 sync_err
);

    logic            w_en, w_acc;
    logic [C_AW-1:0] w_eidx, idx_d, idx_q;
    logic            sync_err_d, sync_err_q;
    cplx_t           x1_d, x1_q;
    tw_t             w1_d, w1_q;
    logic            last1_d, last1_q, v1_d, v1_q;
    cplx_t           w_y;

    // The whole pipeline moves as one; out_ready reaches in_ready combinationally.
    assign w_en   = !out_valid || out_ready;
    assign w_acc  = in_valid && w_en;
    assign w_eidx = in_sop ? '0 : idx_q;

    always_comb begin
        idx_d      = idx_q;
        sync_err_d = sync_err_q;
        x1_d       = x1_q;
        w1_d       = w1_q;
        last1_d    = last1_q;
        v1_d       = v1_q;
        if (w_acc) begin
            idx_d = (w_eidx == C_AW'(N_PT - 1)) ? '0 : w_eidx + 1'b1;
            if (in_sop && idx_q != '0) begin
                sync_err_d = 1'b1;
            end
        end
        if (w_en) begin
            x1_d.re = in_re;
            x1_d.im = in_im;
            w1_d.re = tw_re;
            w1_d.im = tw_im;
            last1_d = (w_eidx == C_AW'(N_PT - 1));
            v1_d    = w_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            sync_err_q <= 1'b0;
            x1_q       <= '0;
            w1_q       <= '0;
            last1_q    <= 1'b0;
            v1_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            sync_err_q <= sync_err_d;
            x1_q       <= x1_d;
            w1_q       <= w1_d;
            last1_q    <= last1_d;
            v1_q       <= v1_d;
        end
    end

    cmul_pipe u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (w_en),
        .in_valid  (v1_q),
        .in_last   (last1_q),
        .x         (x1_q),
        .w         (w1_q),
        .out_valid (out_valid),
        .out_last  (out_last),
        .y         (w_y)
    );

    assign in_ready = w_en;
    assign tw_addr  = w_eidx;
    assign out_re   = w_y.re;
    assign out_im   = w_y.im;
    assign sync_err = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_tw_mul8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_tw_mul8                                               |
// | Description : Directed self-checking bench for fft_tw_mul8.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_tw_mul8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0, in_sop = 1'b0, out_ready = 1'b1;
    logic signed [9:0] in_re = '0, in_im = '0;
    logic              in_ready, out_valid, out_last, sync_err;
    logic [2:0]        tw_addr;
    logic signed [9:0] tw_re, tw_im, out_re, out_im;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam int ROM_RE[8] = '{256, 128, 0,   0,    -256, 64, 256, -128};
    localparam int ROM_IM[8] = '{0,   0,   256, -256, 0,    64, 256, 0};
    // x=(100,0) times each default ROM entry
    localparam int EXP_RE[8] = '{100, 50, 0,   0,    -100, 25, 100, -50};
    localparam int EXP_IM[8] = '{0,   0,  100, -100, 0,    25, 100, 0};

    logic signed [9:0] rom_re [8];
    logic signed [9:0] rom_im [8];

    logic signed [9:0] oq_re [$];
    logic signed [9:0] oq_im [$];
    logic              oq_last [$];
    int                oq_cyc [$];
    int                aq_addr [$];
    int                aq_cyc [$];

    always #5 clk = ~clk;

    always_comb begin
        tw_re = rom_re[tw_addr];
        tw_im = rom_im[tw_addr];
    end

    fft_tw_mul8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_re     (in_re),
        .in_im     (in_im),
        .tw_addr   (tw_addr),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .sync_err  (sync_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                oq_re.push_back(out_re);
                oq_im.push_back(out_im);
                oq_last.push_back(out_last);
                oq_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                aq_addr.push_back(int'(tw_addr));
                aq_cyc.push_back(cyc);
            end
        end
    end

    task automatic init_rom();
        for (int i = 0; i < 8; i++) begin
            rom_re[i] = 10'(ROM_RE[i]);
            rom_im[i] = 10'(ROM_IM[i]);
        end
    endtask

    task automatic clear_queues();
        oq_re.delete();
        oq_im.delete();
        oq_last.delete();
        oq_cyc.delete();
        aq_addr.delete();
        aq_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        out_ready = 1'b1;
        init_rom();
        clear_queues();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input int re, input int im, input logic sop);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_re    = 10'(re);
        in_im    = 10'(im);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: in_ready stuck at 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int k;
        k = 0;
        while (oq_re.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        init_rom();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_re !== 10'sd0) begin errors++; $display("FAIL rst_out_re: got %0d want 0", out_re); end
        checks++; if (out_im !== 10'sd0) begin errors++; $display("FAIL rst_out_im: got %0d want 0", out_im); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
        checks++; if (tw_addr !== 3'd0) begin errors++; $display("FAIL rst_tw_addr: got %0d want 0", tw_addr); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        push(100, 0, 1'b1);
        for (int i = 1; i < 8; i++) push(100, 0, 1'b0);
        wait_outs(8);
        checks++; if (oq_re.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", oq_re.size()); end
        for (int i = 0; i < 8 && i < oq_re.size(); i++) begin
            checks++; if (int'(oq_re[i]) != EXP_RE[i]) begin errors++; $display("FAIL stream_re[%0d]: got %0d want %0d", i, oq_re[i], EXP_RE[i]); end
            checks++; if (int'(oq_im[i]) != EXP_IM[i]) begin errors++; $display("FAIL stream_im[%0d]: got %0d want %0d", i, oq_im[i], EXP_IM[i]); end
            checks++; if (oq_last[i] !== (i == 7)) begin errors++; $display("FAIL stream_last[%0d]: got %b want %b", i, oq_last[i], (i == 7)); end
        end
        for (int i = 0; i < 8 && i < aq_addr.size(); i++) begin
            checks++; if (aq_addr[i] != i) begin errors++; $display("FAIL stream_addr[%0d]: got %0d want %0d", i, aq_addr[i], i); end
        end
        if (oq_cyc.size() > 0 && aq_cyc.size() > 0) begin
            checks++; if (oq_cyc[0] - aq_cyc[0] != 3) begin errors++; $display("FAIL stream_latency: got %0d want 3", oq_cyc[0] - aq_cyc[0]); end
        end
    endtask

    task automatic test_rounding();
        do_reset();
        rom_re[0] = 10'sd128; rom_im[0] = 10'sd0;
        rom_re[1] = 10'sd128; rom_im[1] = 10'sd0;
        push(3, 0, 1'b1);
        push(-3, 0, 1'b0);
        wait_outs(2);
        checks++; if (oq_re.size() != 2) begin errors++; $display("FAIL round_count: got %0d want 2", oq_re.size()); end
        if (oq_re.size() >= 2) begin
            checks++; if (int'(oq_re[0]) != 2) begin errors++; $display("FAIL round_pos_re: got %0d want 2", oq_re[0]); end
            checks++; if (int'(oq_im[0]) != 0) begin errors++; $display("FAIL round_pos_im: got %0d want 0", oq_im[0]); end
            checks++; if (int'(oq_re[1]) != -1) begin errors++; $display("FAIL round_neg_re: got %0d want -1", oq_re[1]); end
            checks++; if (int'(oq_im[1]) != 0) begin errors++; $display("FAIL round_neg_im: got %0d want 0", oq_im[1]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rom_re[0] = 10'sd180;  rom_im[0] = -10'sd180;
        rom_re[1] = 10'sd256;  rom_im[1] = -10'sd256;
        push(511, -511, 1'b1);
        push(-512, -512, 1'b0);
        wait_outs(2);
        checks++; if (oq_re.size() != 2) begin errors++; $display("FAIL sat_count: got %0d want 2", oq_re.size()); end
        if (oq_re.size() >= 2) begin
            checks++; if (int'(oq_re[0]) != 0) begin errors++; $display("FAIL sat_a_re: got %0d want 0", oq_re[0]); end
            checks++; if (int'(oq_im[0]) != -512) begin errors++; $display("FAIL sat_a_im: got %0d want -512", oq_im[0]); end
            checks++; if (int'(oq_re[1]) != -512) begin errors++; $display("FAIL sat_b_re: got %0d want -512", oq_re[1]); end
            checks++; if (int'(oq_im[1]) != 0) begin errors++; $display("FAIL sat_b_im: got %0d want 0", oq_im[1]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fork
            begin
                push(100, 0, 1'b1);
                for (int i = 1; i < 8; i++) push(100, 0, 1'b0);
            end
            begin
                logic signed [9:0] s_re, s_im;
                logic              s_last;
                logic [2:0]        s_addr;
                s_re = '0; s_im = '0; s_last = 1'b0; s_addr = '0;
                repeat (4) @(posedge clk);
                #2;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, out_valid); end
                    if (k == 0) begin
                        s_re = out_re; s_im = out_im; s_last = out_last; s_addr = tw_addr;
                    end else begin
                        checks++; if (out_re !== s_re || out_im !== s_im || out_last !== s_last) begin
                            errors++; $display("FAIL bp_out_stable[%0d]: got (%0d,%0d,%b) want (%0d,%0d,%b)", k, out_re, out_im, out_last, s_re, s_im, s_last);
                        end
                        checks++; if (tw_addr !== s_addr) begin errors++; $display("FAIL bp_addr_frozen[%0d]: got %0d want %0d", k, tw_addr, s_addr); end
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_outs(8);
        checks++; if (oq_re.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", oq_re.size()); end
        for (int i = 0; i < 8 && i < oq_re.size(); i++) begin
            checks++; if (int'(oq_re[i]) != EXP_RE[i] || int'(oq_im[i]) != EXP_IM[i]) begin
                errors++; $display("FAIL bp_data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, oq_re[i], oq_im[i], EXP_RE[i], EXP_IM[i]);
            end
        end
        for (int i = 0; i < 8 && i < aq_addr.size(); i++) begin
            checks++; if (aq_addr[i] != i) begin errors++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, aq_addr[i], i); end
        end
    endtask

    task automatic test_resync();
        int exp_addr[6];
        exp_addr = '{0, 1, 2, 0, 1, 2};
        do_reset();
        push(100, 0, 1'b1);
        push(100, 0, 1'b0);
        push(100, 0, 1'b0);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL resync_err_before: got %b want 0", sync_err); end
        push(100, 0, 1'b1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_err_rise: got %b want 1", sync_err); end
        push(100, 0, 1'b0);
        push(100, 0, 1'b0);
        wait_outs(6);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_err_sticky: got %b want 1", sync_err); end
        checks++; if (aq_addr.size() != 6) begin errors++; $display("FAIL resync_count: got %0d want 6", aq_addr.size()); end
        for (int i = 0; i < 6 && i < aq_addr.size(); i++) begin
            checks++; if (aq_addr[i] != exp_addr[i]) begin errors++; $display("FAIL resync_addr[%0d]: got %0d want %0d", i, aq_addr[i], exp_addr[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(100, 0, 1'b1);
        push(100, 0, 1'b1);
        push(100, 0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL ar_pre_sync_err: got %b want 1", sync_err); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL ar_sync_err: got %b want 0", sync_err); end
        clear_queues();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(100, 0, 1'b0);
        wait_outs(1);
        checks++; if (oq_re.size() != 1) begin errors++; $display("FAIL ar_count: got %0d want 1", oq_re.size()); end
        if (aq_addr.size() > 0) begin
            checks++; if (aq_addr[0] != 0) begin errors++; $display("FAIL ar_addr: got %0d want 0", aq_addr[0]); end
        end
        if (oq_re.size() > 0) begin
            checks++; if (int'(oq_re[0]) != 100 || int'(oq_im[0]) != 0) begin errors++; $display("FAIL ar_data: got (%0d,%0d) want (100,0)", oq_re[0], oq_im[0]); end
        end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL ar_sync_err_after: got %b want 0", sync_err); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_resync();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fft_tw_mul8.md
Name: fft_tw_mul8

Overview:
- Streaming complex multiplier that reads the 8-entry twiddle ROM for the 8-point FFT stage.
- Counts samples within each 8-sample block and drives the ROM address.
- Multiplies each sample by the returned twiddle, rounds and saturates the result.
- Sits between a butterfly stage output and the next stage input, using valid/ready handshakes on both sides.

Parameters:
- DW, 10, data width of the re/im parts of input and output samples (signed).
- TW, 10, twiddle width of re/im (signed, Q2.8 format: +1.0 = 256).
- FRAC, 8, number of twiddle fraction bits dropped after the multiply.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_sop  input  1  sample is index 0 of a block
- in_re  input  DW  input real part, signed
- in_im  input  DW  input imaginary part, signed
- tw_addr  output  3  address to the combinational twiddle ROM
- tw_re  input  TW  ROM real output, same cycle as tw_addr
- tw_im  input  TW  ROM imaginary output, same cycle as tw_addr
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts the sample
- out_re  output  DW  product real part, rounded and saturated
- out_im  output  DW  product imaginary part, rounded and saturated
- out_last  output  1  output sample is index 7 of its block
- sync_err  output  1  sticky: in_sop seen while the index counter was not 0

Behaviour:
- Reset (async, rst=1): idx=0 and all stage valids=0. All outputs reset to 0, except in_ready, which goes to 1 as reset releases.
- Accept: acc = in_valid && in_ready.
- Global advance: en = !out_valid || out_ready. in_ready = en. This is a combinational path from out_ready to in_ready.
- Effective index: eidx = in_sop ? 0 : idx. tw_addr = eidx, driven combinationally every cycle, whether or not in_valid is high.
- Counter update on acc: idx <= (eidx==7) ? 0 : eidx+1. Wraps 7 -> 0.
- Counter holds when there is no acc.
- Sync error: if acc && in_sop && idx!=0, set sync_err=1. It stays set until reset. The counter resyncs to 0 for that sample.
- Pipeline: three register stages, all advancing only when en=1. Latency is 3 cycles from acc to out_valid, with no stalls.
  - S1: capture in_re/in_im, tw_re/tw_im, last=(eidx==7), v1=acc.
  - S2: four signed products, each DW+TW bits: ar=re*wr, bi=im*wi, ai=re*wi, br=im*wr. v2=v1.
  - S3: pr = ar-bi and pi = ai+br, each DW+TW+1 bits.
    - Round half up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
    - Saturate to the signed DW range [-2^(DW-1), 2^(DW-1)-1].
    - Register into out_re/out_im/out_last/out_valid.
- Stall: while out_valid && !out_ready, all stages and idx hold. in_ready=0. Outputs remain stable.
- A bubble (v=0) propagates normally. Data registers may update on bubbles, but out_valid stays 0.
- Reset mid-block: the pipeline is flushed, idx returns to 0, sync_err is cleared.
- No throughput loss: one sample per cycle when out_ready is held high.

Decomposition:
- Shared package fft_pkg holds:
  - constants DW=10, TW=10, FRAC=8, N_PT=8
  - typedef cplx_t, a packed struct of signed re/im [DW-1:0]
  - typedef tw_t, the same struct at TW width
  - function sat_round(), which rounds and saturates a wide signed value to DW bits
- One sub-module is natural: cmul_pipe, the two-stage S2/S3 complex multiply/round/saturate with an enable input. The counter, handshake and S1 logic stay in the top.

Test Plan:
1. Reset, then in_sop=1 and 8 samples of (100,0), with the bench ROM returning (256,0) at addr 0 and (0,-256) at addr 3.
   - Addr-0 sample: (100,0) three cycles later.
   - Addr-3 sample: (0,-100).
   - tw_addr sequence: 0..7.
   - out_last on the 8th output only.
2. Rounding: x=(3,0), tw=(128,0) -> out=(2,0). x=(-3,0), tw=(128,0) -> out=(-1,0).
3. Saturation: x=(511,-511), tw=(180,-180) -> out=(0,-512). x=(-512,-512), tw=(256,-256) -> out_re=-1024 before clipping, so out=(-512,0).
4. Backpressure: stream 8 samples while holding out_ready=0 for 5 cycles mid-stream.
   - in_ready=0 during the stall.
   - out_* stable during the stall.
   - All 8 results delivered in order, none lost or duplicated.
   - tw_addr frozen during the stall.
5. Resync: in_sop asserted on the 4th sample of a block.
   - tw_addr=0 for that sample.
   - sync_err rises and stays 1.
   - The following samples use addr 1,2,...
6. Async reset asserted mid-stream with 2 samples in flight.
   - out_valid=0 immediately.
   - After release, the first sample without in_sop uses tw_addr=0.
   - sync_err=0.
